// File: rtl/int_img_stream.sv
// Streaming integral image (and squared integral with INT_IMG_SQ_EN); 1-cycle latency, registered outputs.
// Backpressure: in_ready only in RUN while the output register is empty or draining, so stalls hold all fields.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 640
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 480
`endif

module int_img_stream #(
  parameter int WIDTH_LIMIT  = `LAPTOP_WIDTH,
  parameter int HEIGHT_LIMIT = `LAPTOP_HEIGHT,
  parameter int PIX_W        = 8,
  parameter int SUM_W        = 18,
  parameter int SQ_W         = 32,
  localparam int XW = (WIDTH_LIMIT  > 1) ? $clog2(WIDTH_LIMIT)  : 1,
  localparam int YW = (HEIGHT_LIMIT > 1) ? $clog2(HEIGHT_LIMIT) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [SQ_W-1:0]   out_sum_sq,
  output logic [XW-1:0]     out_x,
  output logic [YW-1:0]     out_y,
  output logic              out_last,
  output logic              frame_done
);

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH_LIMIT - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d, out_x_q, out_x_d;
  logic [YW-1:0]    y_q, y_d, out_y_q, out_y_d;
  logic [SUM_W-1:0] rowacc_q, rowacc_d, out_sum_q, out_sum_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;
  logic [SUM_W-1:0] colbuf_q [WIDTH_LIMIT];

  logic             in_fire, out_fire, x_end, y_end, start_go;
  logic [SUM_W-1:0] row_next, int_next;

  assign x_end    = (x_q == X_MAX);
  assign y_end    = (y_q == Y_MAX);
  assign start_go = (state_q == IDLE) && start;
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Row 0 ignores colbuf so stale data from an earlier frame never leaks in.
  assign row_next = rowacc_q + SUM_W'(in_pixel);
  assign int_next = row_next + ((y_q == '0) ? '0 : colbuf_q[x_q]);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    rowacc_d     = rowacc_q;
    out_sum_d    = out_sum_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          x_d      = '0;
          y_d      = '0;
          rowacc_d = '0;
        end
      end
      RUN: begin
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_sum_d   = int_next;
          out_x_d     = x_q;
          out_y_d     = y_q;
          out_last_d  = x_end && y_end;
          if (x_end) begin
            x_d      = '0;
            rowacc_d = '0;
            y_d      = y_end ? '0 : y_q + 1'b1;
            if (y_end) state_d = DRAIN;
          end else begin
            x_d      = x_q + 1'b1;
            rowacc_d = row_next;
          end
        end
      end
      DRAIN: begin
        if (out_fire && out_last_q) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      rowacc_q     <= '0;
      out_sum_q    <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rowacc_q     <= rowacc_d;
      out_sum_q    <= out_sum_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (in_fire) colbuf_q[x_q] <= int_next;
  end

`ifdef INT_IMG_SQ_EN
  logic [2*PIX_W-1:0] pix_ext, pix_sq;
  logic [SQ_W-1:0]    rowsq_q, rowsq_d, out_sq_q, out_sq_d, rowsq_next, sq_next;
  logic [SQ_W-1:0]    colsq_q [WIDTH_LIMIT];

  assign pix_ext    = {{PIX_W{1'b0}}, in_pixel};
  assign pix_sq     = pix_ext * pix_ext;
  assign rowsq_next = rowsq_q + SQ_W'(pix_sq);
  assign sq_next    = rowsq_next + ((y_q == '0) ? '0 : colsq_q[x_q]);

  always_comb begin
    rowsq_d  = rowsq_q;
    out_sq_d = out_sq_q;
    if (start_go) begin
      rowsq_d = '0;
    end else if (in_fire) begin
      out_sq_d = sq_next;
      rowsq_d  = x_end ? '0 : rowsq_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rowsq_q  <= '0;
      out_sq_q <= '0;
    end else begin
      rowsq_q  <= rowsq_d;
      out_sq_q <= out_sq_d;
    end
  end

  always_ff @(posedge clock) begin
    if (in_fire) colsq_q[x_q] <= sq_next;
  end

  assign out_sum_sq = out_sq_q;
`else
  logic unused_start_go;
  assign unused_start_go = start_go;
  assign out_sum_sq      = '0;
`endif

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule
